// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM inputs, data-memory bus and MEM/WB outputs of the memory stage.
interface mem_stage_if;
  logic [31:0] alu_result, branch_result, mem_write_data, dmem_rdata;
  logic [31:0] dmem_addr, dmem_wdata, branch_target, wb_read_data, wb_alu_result;
  logic [4:0] write_reg_addr, wb_write_reg_addr;
  logic alu_zero, mem_read, mem_write, mem_reg, branch, reg_write, dmem_ready;
  logic dmem_req, dmem_we, stall, pc_src, wb_mem_reg, wb_reg_write, bus_error;
  modport master (
    input alu_result, alu_zero, branch_result, write_reg_addr, mem_read, mem_write,
          mem_reg, branch, reg_write, mem_write_data, dmem_rdata, dmem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, pc_src, branch_target,
           wb_read_data, wb_alu_result, wb_write_reg_addr, wb_mem_reg, wb_reg_write, bus_error
  );
  modport slave (
    output alu_result, alu_zero, branch_result, write_reg_addr, mem_read, mem_write,
           mem_reg, branch, reg_write, mem_write_data, dmem_rdata, dmem_ready,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, pc_src, branch_target,
          wb_read_data, wb_alu_result, wb_write_reg_addr, wb_mem_reg, wb_reg_write, bus_error
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage with req/ready data bus, wait-state stall,
// access timeout, branch resolution and the MEM/WB register.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  mem_stage_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, WAIT} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] wb_read_data_q, wb_read_data_d, wb_alu_result_q, wb_alu_result_d;
  logic [4:0] wb_addr_q, wb_addr_d;
  logic wb_mem_reg_q, wb_mem_reg_d, wb_reg_write_q, wb_reg_write_d, bus_error_q, bus_error_d;
  logic access, misaligned, timeout_hit, req, stall, err;
  assign access = bus.mem_read | bus.mem_write;
  assign misaligned = access & (bus.alu_result[1:0] != 2'b00);
  assign timeout_hit = (state_q == WAIT) & (cnt_q == CW'(TIMEOUT));
  // rst_n in the request term lets an in-flight access drop without waiting for a clock
  assign req = access & ~misaligned & ~timeout_hit & rst_n;
  assign stall = req & ~bus.dmem_ready;
  assign err = misaligned | timeout_hit;
  assign bus.dmem_req = req;
  assign bus.dmem_we = bus.mem_write;
  assign bus.dmem_addr = bus.alu_result;
  assign bus.dmem_wdata = bus.mem_write_data;
  assign bus.stall = stall;
  assign bus.pc_src = bus.branch & bus.alu_zero & ~stall & rst_n;
  assign bus.branch_target = bus.branch_result;
  assign bus.wb_read_data = wb_read_data_q;
  assign bus.wb_alu_result = wb_alu_result_q;
  assign bus.wb_write_reg_addr = wb_addr_q;
  assign bus.wb_mem_reg = wb_mem_reg_q;
  assign bus.wb_reg_write = wb_reg_write_q;
  assign bus.bus_error = bus_error_q;
  always_comb begin
    state_d = stall ? WAIT : IDLE;
    cnt_d = stall ? cnt_q + CW'(1) : '0;
  end
  // A stalled edge inserts a bubble; a faulted access captures everything but the write-back
  always_comb begin
    wb_alu_result_d = stall ? wb_alu_result_q : bus.alu_result;
    wb_addr_d = stall ? wb_addr_q : bus.write_reg_addr;
    wb_mem_reg_d = stall ? wb_mem_reg_q : bus.mem_reg;
    wb_reg_write_d = ~stall & bus.reg_write & ~err;
    wb_read_data_d = stall ? wb_read_data_q : ((bus.mem_read & ~err) ? bus.dmem_rdata : 32'h0);
    bus_error_d = bus_error_q | (~stall & err);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wb_read_data_q <= '0;
      wb_alu_result_q <= '0;
      wb_addr_q <= '0;
      wb_mem_reg_q <= 1'b0;
      wb_reg_write_q <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wb_read_data_q <= wb_read_data_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_addr_q <= wb_addr_d;
      wb_mem_reg_q <= wb_mem_reg_d;
      wb_reg_write_q <= wb_reg_write_d;
      bus_error_q <= bus_error_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios for mem_stage with TIMEOUT=4.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  mem_stage_if bus();
  mem_stage #(.TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic set_idle();
    bus.alu_result = 32'h0; bus.alu_zero = 1'b0; bus.branch_result = 32'h0;
    bus.write_reg_addr = 5'd0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.mem_reg = 1'b0; bus.branch = 1'b0; bus.reg_write = 1'b0;
    bus.mem_write_data = 32'h0; bus.dmem_rdata = 32'h0; bus.dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    bus.mem_read = 1'b1; bus.alu_result = 32'h100; bus.branch = 1'b1; bus.alu_zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%h exp=0", bus.dmem_req); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%h exp=0", bus.stall); end
    checks++; if (bus.pc_src !== 1'b0) begin failures++; $display("FAIL reset_pc_src got=%h exp=0", bus.pc_src); end
    checks++; if (bus.wb_read_data !== 32'h0 || bus.wb_alu_result !== 32'h0) begin failures++; $display("FAIL reset_wb_data got=%h/%h exp=0/0", bus.wb_read_data, bus.wb_alu_result); end
    checks++; if (bus.wb_write_reg_addr !== 5'd0 || bus.wb_mem_reg !== 1'b0 || bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL reset_wb_ctrl got=%h/%h/%h exp=0/0/0", bus.wb_write_reg_addr, bus.wb_mem_reg, bus.wb_reg_write); end
    checks++; if (bus.bus_error !== 1'b0) begin failures++; $display("FAIL reset_bus_error got=%h exp=0", bus.bus_error); end
    set_idle();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (int'(dut.state_q) !== 0 || dut.cnt_q !== '0) begin failures++; $display("FAIL reset_fsm got=%0d/%0d exp=0/0", int'(dut.state_q), dut.cnt_q); end
  endtask

  task automatic test_zero_wait_load();
    @(negedge clk);
    bus.mem_read = 1'b1; bus.reg_write = 1'b1; bus.mem_reg = 1'b1; bus.alu_result = 32'h100;
    bus.write_reg_addr = 5'd5; bus.dmem_rdata = 32'hDEADBEEF; bus.dmem_ready = 1'b1;
    #1;
    checks++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 32'h100) begin failures++; $display("FAIL zw_bus got=%h/%h/%h exp=1/0/100", bus.dmem_req, bus.dmem_we, bus.dmem_addr); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL zw_stall got=%h exp=0", bus.stall); end
    @(posedge clk); #1;
    checks++; if (bus.wb_read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL zw_rdata got=%h exp=deadbeef", bus.wb_read_data); end
    checks++; if (bus.wb_write_reg_addr !== 5'd5 || bus.wb_reg_write !== 1'b1 || bus.wb_mem_reg !== 1'b1) begin failures++; $display("FAIL zw_ctrl got=%h/%h/%h exp=5/1/1", bus.wb_write_reg_addr, bus.wb_reg_write, bus.wb_mem_reg); end
    checks++; if (bus.wb_alu_result !== 32'h100) begin failures++; $display("FAIL zw_alu got=%h exp=100", bus.wb_alu_result); end
    set_idle();
  endtask

  task automatic test_wait_store();
    int stalls = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_write = 1'b1; bus.alu_result = 32'h204; bus.mem_write_data = 32'h12345678;
      bus.write_reg_addr = 5'd6; bus.dmem_ready = (i == 3);
      #1;
      if (bus.stall === 1'b1) stalls++;
      checks++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 || bus.dmem_wdata !== 32'h12345678) begin failures++; $display("FAIL st_bus[%0d] got=%h/%h/%h exp=1/1/12345678", i, bus.dmem_req, bus.dmem_we, bus.dmem_wdata); end
      if (i > 0) begin
        checks++; if (bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL st_bubble[%0d] got=%h exp=0", i, bus.wb_reg_write); end
      end
    end
    @(posedge clk); #1;
    checks++; if (stalls != 3) begin failures++; $display("FAIL st_stall_cycles got=%0d exp=3", stalls); end
    checks++; if (bus.wb_alu_result !== 32'h204 || bus.wb_reg_write !== 1'b0 || bus.wb_read_data !== 32'h0) begin failures++; $display("FAIL st_wb got=%h/%h/%h exp=204/0/0", bus.wb_alu_result, bus.wb_reg_write, bus.wb_read_data); end
    checks++; if (bus.bus_error !== 1'b0) begin failures++; $display("FAIL st_bus_error got=%h exp=0", bus.bus_error); end
    set_idle();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.mem_read = 1'b1; bus.reg_write = 1'b1; bus.alu_result = 32'h300;
      bus.write_reg_addr = 5'd7; bus.dmem_rdata = 32'hCAFEF00D; bus.dmem_ready = (i == 4);
      #1;
      checks++; if (bus.stall !== (i < 4) || bus.dmem_req !== (i < 4)) begin failures++; $display("FAIL to_cycle[%0d] got=%h/%h exp=%h/%h", i, bus.stall, bus.dmem_req, i < 4, i < 4); end
    end
    @(posedge clk); #1;
    checks++; if (bus.bus_error !== 1'b1 || bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL to_abort got=%h/%h exp=1/0", bus.bus_error, bus.wb_reg_write); end
    checks++; if (bus.wb_read_data !== 32'h0 || bus.wb_write_reg_addr !== 5'd7 || bus.wb_alu_result !== 32'h300) begin failures++; $display("FAIL to_wb got=%h/%h/%h exp=0/7/300", bus.wb_read_data, bus.wb_write_reg_addr, bus.wb_alu_result); end
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.bus_error !== 1'b1) begin failures++; $display("FAIL to_sticky got=%h exp=1", bus.bus_error); end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    bus.mem_read = 1'b1; bus.reg_write = 1'b1; bus.alu_result = 32'h400; bus.write_reg_addr = 5'd8;
    bus.branch = 1'b1; bus.alu_zero = 1'b1; bus.dmem_ready = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b1 || bus.pc_src !== 1'b0) begin failures++; $display("FAIL mr_pre got=%h/%h exp=1/0", bus.stall, bus.pc_src); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || bus.stall !== 1'b0 || bus.pc_src !== 1'b0) begin failures++; $display("FAIL mr_async got=%h/%h/%h exp=0/0/0", bus.dmem_req, bus.stall, bus.pc_src); end
    checks++; if (bus.bus_error !== 1'b0 || bus.wb_reg_write !== 1'b0 || bus.wb_alu_result !== 32'h0 || bus.wb_write_reg_addr !== 5'd0) begin failures++; $display("FAIL mr_wb got=%h/%h/%h/%h exp=0/0/0/0", bus.bus_error, bus.wb_reg_write, bus.wb_alu_result, bus.wb_write_reg_addr); end
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (int'(dut.state_q) !== 0 || bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL mr_idle got=%0d/%h exp=0/0", int'(dut.state_q), bus.wb_reg_write); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    bus.mem_read = 1'b1; bus.reg_write = 1'b1; bus.alu_result = 32'h102; bus.write_reg_addr = 5'd9;
    bus.dmem_rdata = 32'hAAAA5555; bus.dmem_ready = 1'b1;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || bus.stall !== 1'b0) begin failures++; $display("FAIL mis_bus got=%h/%h exp=0/0", bus.dmem_req, bus.stall); end
    @(posedge clk); #1;
    checks++; if (bus.bus_error !== 1'b1 || bus.wb_reg_write !== 1'b0 || bus.wb_read_data !== 32'h0) begin failures++; $display("FAIL mis_wb got=%h/%h/%h exp=1/0/0", bus.bus_error, bus.wb_reg_write, bus.wb_read_data); end
    checks++; if (bus.wb_write_reg_addr !== 5'd9 || bus.wb_alu_result !== 32'h102) begin failures++; $display("FAIL mis_capture got=%h/%h exp=9/102", bus.wb_write_reg_addr, bus.wb_alu_result); end
    set_idle();
  endtask

  task automatic test_branch();
    @(negedge clk);
    bus.branch = 1'b1; bus.alu_zero = 1'b1; bus.branch_result = 32'h40;
    bus.reg_write = 1'b1; bus.write_reg_addr = 5'd3; bus.alu_result = 32'h55; bus.dmem_ready = 1'b1;
    #1;
    checks++; if (bus.pc_src !== 1'b1 || bus.branch_target !== 32'h40) begin failures++; $display("FAIL br_taken got=%h/%h exp=1/40", bus.pc_src, bus.branch_target); end
    checks++; if (bus.dmem_req !== 1'b0 || bus.stall !== 1'b0) begin failures++; $display("FAIL br_noreq got=%h/%h exp=0/0", bus.dmem_req, bus.stall); end
    bus.alu_zero = 1'b0;
    #1;
    checks++; if (bus.pc_src !== 1'b0) begin failures++; $display("FAIL br_not_taken got=%h exp=0", bus.pc_src); end
    @(posedge clk); #1;
    checks++; if (bus.wb_reg_write !== 1'b1 || bus.wb_alu_result !== 32'h55 || bus.wb_write_reg_addr !== 5'd3 || bus.wb_read_data !== 32'h0) begin failures++; $display("FAIL br_pass got=%h/%h/%h/%h exp=1/55/3/0", bus.wb_reg_write, bus.wb_alu_result, bus.wb_write_reg_addr, bus.wb_read_data); end
    set_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [4] = '{32'h0, 32'h11111111, 32'h0, 32'h22222222};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_read = 1'b1; bus.reg_write = 1'b1; bus.write_reg_addr = (i < 2) ? 5'd10 : 5'd11;
      bus.alu_result = (i < 2) ? 32'h500 : 32'h504; bus.dmem_rdata = rd[i]; bus.dmem_ready = i[0];
      #1;
      checks++; if (bus.dmem_req !== 1'b1 || bus.stall !== !i[0]) begin failures++; $display("FAIL b2b_cycle[%0d] got=%h/%h exp=1/%h", i, bus.dmem_req, bus.stall, !i[0]); end
      if (i == 2) begin
        checks++; if (dut.cnt_q !== '0) begin failures++; $display("FAIL b2b_cnt got=%0d exp=0", dut.cnt_q); end
      end
      @(posedge clk); #1;
      if (i[0]) begin
        checks++; if (bus.wb_read_data !== rd[i] || bus.wb_reg_write !== 1'b1 || bus.wb_write_reg_addr !== ((i < 2) ? 5'd10 : 5'd11)) begin failures++; $display("FAIL b2b_wb[%0d] got=%h/%h/%h exp=%h/1", i, bus.wb_read_data, bus.wb_reg_write, bus.wb_write_reg_addr, rd[i]); end
      end else begin
        checks++; if (bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL b2b_bubble[%0d] got=%h exp=0", i, bus.wb_reg_write); end
      end
    end
    set_idle();
    @(negedge clk);
    bus.dmem_ready = 1'b1; bus.dmem_rdata = 32'h33333333;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || bus.stall !== 1'b0) begin failures++; $display("FAIL b2b_idle_ready got=%h/%h exp=0/0", bus.dmem_req, bus.stall); end
    @(posedge clk); #1;
    checks++; if (bus.wb_read_data !== 32'h0 || bus.wb_reg_write !== 1'b0) begin failures++; $display("FAIL b2b_idle_wb got=%h/%h exp=0/0", bus.wb_read_data, bus.wb_reg_write); end
    set_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait_load();
    test_wait_store();
    test_timeout();
    test_reset_mid_access();
    test_misaligned();
    test_branch();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
